audio_pwm_player: RTL
=====================

# audio_pwm_player

Parametrised multi-channel audio playback engine: buffers packed PCM sample words from the MicroBlaze GPIO/AXI side in an internal FIFO, pops one word per sample period from an internal sample-rate divider, and drives per-channel and mono-mixed PWM speaker outputs. It replaces the fixed single-channel FIFO, 44 kHz counter and modulator chain feeding SPKL/SPKR, and adds volume, mute, a refill interrupt and underrun reporting.

## Interface
- CHANNELS, 2, channel count; 1, 2 or 4 (power of two)
- SAMPLE_W, 8, unsigned sample width; also the PWM resolution
- DEPTH, 16, FIFO depth in words; power of two, at least 4
- AE_THRESH, 4, almost_empty asserts when level <= AE_THRESH
- CLK_HZ, 100000000, Clk frequency
- SAMPLE_HZ, 44100, sample rate; DIV = CLK_HZ/SAMPLE_HZ (truncated), at least 2
- Clk  in  1  system clock; all state on its rising edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  1 = play; 0 = divider and PWM held, outputs low
- wr_data  in  CHANNELS*SAMPLE_W  packed samples; channel c = bits [c*SAMPLE_W +: SAMPLE_W]
- wr_valid  in  1  write request
- wr_ready  out  1  FIFO not full
- vol_shift  in  2  attenuation; duty = sample >> vol_shift
- mute  in  1  forces all PWM outputs low; FIFO draining continues
- clr_underrun  in  1  clears underrun sticky flag
- spk  out  CHANNELS  per-channel PWM
- spk_mix  out  1  PWM of the channel average
- level  out  $clog2(DEPTH+1)  FIFO word count
- empty  out  1  level == 0
- almost_empty  out  1  level <= AE_THRESH (refill request to CPU)
- underrun  out  1  sticky: a sample tick found the FIFO empty
- sample_tick  out  1  one-cycle pulse per sample period

## Operation
- FIFO: push when wr_valid && wr_ready; wr_ready = (level != DEPTH), combinational from registered count. Write while full is ignored and not stored.
- Divider: counts 0..DIV-1 while enable=1; sample_tick = 1 in the cycle the count equals DIV-1, then count wraps to 0. enable=0 holds count at 0, no ticks.
- On sample_tick: FIFO non-empty -> pop head word into sample registers; empty -> sample registers load 0 and underrun sets.
- Same-cycle push and pop: both occur, level unchanged. Push into empty FIFO in a tick cycle: pop sees empty (underrun, samples 0); pushed word stays, level becomes 1.
- Mix: sum of all channel samples (width SAMPLE_W+log2(CHANNELS)), right-shifted by log2(CHANNELS), then shifted by vol_shift.
- PWM: free-running SAMPLE_W-bit counter pwm_cnt (advances only when enable=1). Active duty registers reload from (sample >> vol_shift) only when pwm_cnt == 2^SAMPLE_W-1, so no mid-period glitches. spk[c] = enable && !mute && (pwm_cnt < duty[c]); same for spk_mix. Duty 0 -> always low; max duty = (2^SAMPLE_W-1)/2^SAMPLE_W.
- underrun: set on tick-while-empty, cleared by clr_underrun; set wins if both in same cycle.

## Timing
- Reset (async assert, sync release): FIFO pointers/level 0, divider 0, pwm_cnt 0, samples and duties 0; outputs spk=0, spk_mix=0, wr_ready=1, level=0, empty=1, almost_empty=1, underrun=0, sample_tick=0. Reset mid-playback discards all buffered data immediately.
- Write latency: level/empty update the cycle after the accepting edge.
- Pop: sample registers valid the cycle after sample_tick; reach pins at the next PWM period boundary (max 2^SAMPLE_W+1 cycles).
- PWM period exactly 2^SAMPLE_W Clk cycles; outputs registered.
- Pointer wrap at DEPTH without loss; level counts 0..DEPTH inclusive.

## Test plan
- Reset: CLK_HZ=1000, SAMPLE_HZ=100 (DIV=10); hold reset_n=0 -> all outputs at reset values; wr_ready=1, almost_empty=1.
- Fill/overflow: DEPTH=16, enable=0, 20 writes -> level=16, wr_ready=0 after 16th, words 17-20 dropped; playback emits first 16 in order.
- Playback/duty: CHANNELS=2, SAMPLE_W=8, word {8'd64,8'd192} -> after period boundary spk[0] high 192/256 cycles, spk[1] 64/256, spk_mix 128/256; vol_shift=1 -> 96, 32, 64.
- Underrun: one word then enable -> second tick sets underrun, spk low; clr_underrun -> 0; clr with simultaneous tick-while-empty -> stays 1.
- Simultaneous push/pop: level=3, write in tick cycle -> level stays 3; almost_empty toggles at level 4/5 crossing with AE_THRESH=4.
- Mute/async reset: mute=1 -> spk/spk_mix low while level decrements once per 10 cycles; reset_n low mid-period -> outputs 0 same cycle, level 0.

Source files
------------

// File: rtl/audio_pwm_player.sv
// audio_pwm_player: FIFO-buffered multi-channel PCM playback with per-channel and mixed PWM outputs,
// volume shift, mute, refill threshold and sticky underrun reporting.
module audio_pwm_player #(
   parameter int CHANNELS  = 2,
   parameter int SAMPLE_W  = 8,
   parameter int DEPTH     = 16,
   parameter int AE_THRESH = 4,
   parameter int CLK_HZ    = 100000000,
   parameter int SAMPLE_HZ = 44100
) (
   input  logic                             Clk,
   input  logic                             reset_n,
   input  logic                             enable,
   input  logic [CHANNELS*SAMPLE_W-1:0]     wr_data,
   input  logic                             wr_valid,
   output logic                             wr_ready,
   input  logic [1:0]                       vol_shift,
   input  logic                             mute,
   input  logic                             clr_underrun,
   output logic [CHANNELS-1:0]              spk,
   output logic                             spk_mix,
   output logic [$clog2(DEPTH+1)-1:0]       level,
   output logic                             empty,
   output logic                             almost_empty,
   output logic                             underrun,
   output logic                             sample_tick
);
   localparam int DIV = CLK_HZ / SAMPLE_HZ;
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = $clog2(DEPTH + 1);
   localparam int CW  = $clog2(CHANNELS);
   localparam int SW  = SAMPLE_W + CW;
   localparam int W   = CHANNELS * SAMPLE_W;

   logic [W-1:0]        mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [LW-1:0]       count;
   logic [DW-1:0]       div_cnt;
   logic [SAMPLE_W-1:0] pwm_cnt, duty_mix, duty_mix_nxt, mix_avg;
   logic [W-1:0]        samp, duty, duty_nxt;
   logic [SW-1:0]       mix_sum;
   logic [CHANNELS-1:0] spk_nxt;
   logic                push, pop, reload;

   assign wr_ready     = count != LW'(DEPTH);
   assign empty        = count == '0;
   assign almost_empty = count <= LW'(AE_THRESH);
   assign level        = count;
   assign sample_tick  = enable && (div_cnt == DW'(DIV - 1));
   assign push         = wr_valid && wr_ready;
   assign pop          = sample_tick && !empty;
   // duties only change at the period boundary so a period never mixes two samples
   assign reload       = enable && (pwm_cnt == '1);

   always_ff @(posedge Clk)
      if (push) mem[wr_ptr] <= wr_data;

   always_comb begin
      mix_sum  = '0;
      duty_nxt = '0;
      spk_nxt  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         duty_nxt[c*SAMPLE_W +: SAMPLE_W] = samp[c*SAMPLE_W +: SAMPLE_W] >> vol_shift;
         mix_sum    = mix_sum + SW'(samp[c*SAMPLE_W +: SAMPLE_W]);
         spk_nxt[c] = enable && !mute && (pwm_cnt < duty[c*SAMPLE_W +: SAMPLE_W]);
      end
      mix_avg      = SAMPLE_W'(mix_sum >> CW);
      duty_mix_nxt = mix_avg >> vol_shift;
   end

   always_ff @(posedge Clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         div_cnt  <= '0;
         samp     <= '0;
         underrun <= 1'b0;
         pwm_cnt  <= '0;
         duty     <= '0;
         duty_mix <= '0;
         spk      <= '0;
         spk_mix  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count    <= count + LW'(push) - LW'(pop);
         div_cnt  <= (!enable || sample_tick) ? '0 : div_cnt + 1'b1;
         if (sample_tick) samp <= empty ? '0 : mem[rd_ptr];
         underrun <= (sample_tick && empty) || (underrun && !clr_underrun);
         if (enable) pwm_cnt <= pwm_cnt + 1'b1;
         if (reload) begin
            duty     <= duty_nxt;
            duty_mix <= duty_mix_nxt;
         end
         spk      <= spk_nxt;
         spk_mix  <= enable && !mute && (pwm_cnt < duty_mix);
      end
endmodule
